// File: rtl/lia_reference_mixer.sv
// Lock-in reference mixer: a phase-accumulator NCO drives a quarter-wave sine
// ROM, and each valid ADC sample is multiplied by the matching reference value.
// The rounded and saturated product leaves on a sample/valid stream exactly
// 4 cycles after the input strobe. Gaps in the input stream are preserved.
module lia_reference_mixer #(
  parameter int phase_width    = 32,
  parameter int lut_addr_width = 10,
  parameter int word_width     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [phase_width-1:0]       phase_inc,
  input  logic [phase_width-1:0]       phase_offset,
  input  logic                         phase_reset,
  input  logic signed [word_width-1:0] sample_in,
  input  logic                         sample_in_valid,
  output logic signed [word_width-1:0] ref_out,
  output logic signed [word_width-1:0] mix_out,
  output logic                         mix_out_valid
);

  localparam int W     = word_width;
  localparam int W2    = 2 * word_width;
  localparam int PW    = phase_width;
  localparam int LA    = lut_addr_width;
  localparam int LUT_N = 1 << lut_addr_width;
  localparam int LOW   = PW - 2 - LA;
  localparam int STAGES = 5;
  localparam real PI   = 3.14159265358979323846;

  localparam logic signed [W2-1:0] RND  = {{(W2-W+1){1'b0}}, 1'b1, {(W-2){1'b0}}};
  localparam logic signed [W2-1:0] MAXV = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [W2-1:0] MINV = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  // Quarter-wave sample taken at the centre of each bin, so the folded
  // quadrants never land on 0 or on the most negative code.
  function automatic logic [W-1:0] lut_entry(input int k);
    real a;
    a = (2.0 ** (W - 1) - 1.0) * $sin(2.0 * PI * (real'(k) + 0.5) / (4.0 * LUT_N));
    return W'($rtoi(a + 0.5));
  endfunction

  logic [W-1:0] rom [LUT_N];
  for (genvar g = 0; g < LUT_N; g++) begin : g_rom
    assign rom[g] = lut_entry(g);
  end

  // NCO state
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] phase;
  logic          unused_phase;

  // Pipeline registers (vld_q[i] qualifies stage i+1)
  logic [STAGES-1:0]      vld_q;
  logic signed [W-1:0]    s1_smp_q, s2_smp_q, s3_smp_q;
  logic [1:0]             s1_quad_q;
  logic [LA-1:0]          s1_k_q;
  logic [W-1:0]           s2_lut_q;
  logic                   s2_neg_q;
  logic signed [W-1:0]    s3_ref_q, s4_ref_q;
  logic signed [W2-1:0]   s4_prod_q;
  logic signed [W-1:0]    ref_q, mix_q;
  logic signed [W2-1:0]   rnd_sum, rnd_sh;

  // A coincident phase_reset makes this sample see phase_offset alone.
  assign phase        = (phase_reset ? '0 : acc_q) + phase_offset;
  assign unused_phase = ^phase[LOW-1:0];

  // Accumulator next state: clear on phase_reset, step on each valid sample.
  always_comb begin
    acc_d = acc_q;
    if (phase_reset)          acc_d = sample_in_valid ? phase_inc : '0;
    else if (sample_in_valid) acc_d = acc_q + phase_inc;
  end

  // Accumulator and valid shift register; only these need clearing to
  // discard in-flight work on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      vld_q <= '0;
    end else begin
      acc_q <= acc_d;
      vld_q <= {vld_q[STAGES-2:0], sample_in_valid};
    end
  end

  // S1: capture sample, quadrant and ROM index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_smp_q  <= '0;
      s1_quad_q <= '0;
      s1_k_q    <= '0;
    end else if (sample_in_valid) begin
      s1_smp_q  <= sample_in;
      s1_quad_q <= phase[PW-1 -: 2];
      s1_k_q    <= phase[PW-3 -: LA];
    end
  end

  // S2: registered ROM read; odd quadrants walk the table backwards (~k = N-1-k).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_lut_q <= '0;
      s2_neg_q <= 1'b0;
      s2_smp_q <= '0;
    end else if (vld_q[0]) begin
      s2_lut_q <= rom[s1_quad_q[0] ? ~s1_k_q : s1_k_q];
      s2_neg_q <= s1_quad_q[1];
      s2_smp_q <= s1_smp_q;
    end
  end

  // S2b: apply the lower-half-cycle sign to form the signed reference.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_ref_q <= '0;
      s3_smp_q <= '0;
    end else if (vld_q[1]) begin
      s3_ref_q <= s2_neg_q ? -$signed(s2_lut_q) : $signed(s2_lut_q);
      s3_smp_q <= s2_smp_q;
    end
  end

  // S3: full-precision signed product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s4_prod_q <= '0;
      s4_ref_q  <= '0;
    end else if (vld_q[2]) begin
      s4_prod_q <= W2'(s3_ref_q) * W2'(s3_smp_q);
      s4_ref_q  <= s3_ref_q;
    end
  end

  assign rnd_sum = s4_prod_q + RND;
  assign rnd_sh  = rnd_sum >>> (W - 1);

  // S4: round half up, clamp, and hold outputs between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mix_q <= '0;
      ref_q <= '0;
    end else if (vld_q[3]) begin
      if (rnd_sh > MAXV)      mix_q <= MAXV[W-1:0];
      else if (rnd_sh < MINV) mix_q <= MINV[W-1:0];
      else                    mix_q <= rnd_sh[W-1:0];
      ref_q <= s4_ref_q;
    end
  end

  assign mix_out       = mix_q;
  assign ref_out       = ref_q;
  assign mix_out_valid = vld_q[STAGES-1];

endmodule

// File: doc/lia_reference_mixer.md
Name: lia_reference_mixer

Overview:
- Lock-in demodulation front end: multiplies each incoming ADC sample by a sample-synchronous sine reference from an internal NCO (phase accumulator plus quarter-wave LUT).
- Emits the rounded product as a word_width sample/valid stream that feeds the LIA low-pass filter cascade directly.
- Also emits the reference value used for each product, for debug and for the dither DAC path.

Parameters:
- phase_width, 32, phase accumulator width in bits.
- lut_addr_width, 10, quarter-wave LUT address bits; N = 2^lut_addr_width entries.
- word_width (from opo_package), sample width W; all samples are signed two's complement.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- phase_inc  in  phase_width  NCO increment per valid input sample.
- phase_offset  in  phase_width  constant phase added to the accumulator before lookup.
- phase_reset  in  1  synchronous pulse that clears the accumulator.
- sample_in  in  W  signed input sample.
- sample_in_valid  in  1  input strobe; may be high on every cycle.
- ref_out  out  W  reference value used for the sample currently on mix_out.
- mix_out  out  W  rounded product.
- mix_out_valid  out  1  output strobe.

Behaviour:
- Reset (rst low, asynchronous): accumulator = 0, all pipeline valids = 0, ref_out = 0, mix_out = 0, mix_out_valid = 0. The first valid sample after release uses phase = phase_offset.
- Phase per sample: phase = acc + phase_offset, computed mod 2^phase_width.
  - On a valid sample, acc <= acc + phase_inc after use.
  - When sample_in_valid is low, acc holds.
- phase_reset high:
  - acc <= 0 this cycle.
  - If sample_in_valid is high in the same cycle, that sample uses phase = phase_offset and acc <= phase_inc.
- LUT addressing: q = phase[top 2 bits], k = next lut_addr_width bits. Lower bits are truncated, with no dithering.
- LUT content: LUT[k] = round((2^(W-1)-1) * sin(2*pi*(k+0.5)/(4N))). The LUT is a synthesizable ROM initialized by a function at elaboration.
- Reference value by quadrant:
  - q=0: LUT[k]
  - q=1: LUT[N-1-k]
  - q=2: -LUT[k]
  - q=3: -LUT[N-1-k]
  - The reference therefore never equals -2^(W-1).
- Pipeline, fixed latency of 4 cycles (sample_in_valid at edge t gives mix_out_valid at edge t+4). Full throughput, and input gap patterns are preserved exactly.
  - S1: register sample, q, k.
  - S2: LUT read and quadrant mirroring.
  - S3: signed W x W multiply to 2W bits.
  - S4: round and saturate.
- Rounding: out = (P + 2^(W-2)) >>> (W-1), i.e. round half toward +inf. The result is clamped to [-2^(W-1), 2^(W-1)-1].
- Output hold: mix_out and ref_out hold their last values while mix_out_valid is low. mix_out_valid is a 1-cycle strobe per sample.
- Control inputs: phase_inc and phase_offset changes take effect on the next valid sample, with no glitch to data already in flight.
- Reset mid-stream: in-flight samples are discarded, with no late valids after release.

Test Plan (W=16, lut_addr_width=10):
1. Quadrant sweep.
   - Stimulus: phase_inc=2^30, phase_offset=0, four back-to-back valids with sample_in=16384.
   - Required: ref_out = 25, 32767, -25, -32767; mix_out = 13, 16384, -12, -16383.
2. Latency and gaps.
   - Stimulus: valid pattern 1,1,0,1,1,1,0,1 starting at edge t.
   - Required: mix_out_valid shows the identical pattern starting at edge t+4, with no extra strobes.
3. Phase gating.
   - Stimulus: phase_inc=2^30, valid pattern 1,0,0,1, sample_in=16384.
   - Required: the second output uses q=1, giving ref_out=32767 and mix_out=16384.
4. Coincident phase_reset.
   - Stimulus: after three valids, assert phase_reset together with a fourth valid, then send a fifth valid.
   - Required: the fourth output has ref_out=25; the fifth has ref_out=32767.
5. Offset.
   - Stimulus: phase_offset=2^31, first sample 16384 after reset.
   - Required: ref_out=-25, mix_out=-12.
6. Mid-stream reset.
   - Stimulus: drop rst with 3 samples in flight.
   - Required: mix_out_valid=0 and mix_out=0 immediately. No valids appear in the 4 cycles after release. The next sample uses phase=phase_offset.
